// File: rtl/demux2x4_8bits_pkg.sv
// Shared types and helpers for the 2-to-4 lane demultiplexer.
// Phase encodings and the resync (all-lanes-invalid) predicate live here.
package demux2x4_8bits_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_EVEN = 2'd1,
        ST_ODD  = 2'd2
    } phase_e;

    // A word whose four lane valids are all low drops the phase lock.
    function automatic logic word_all_invalid(input logic v0, input logic v1,
                                              input logic v2, input logic v3);
        return ~(v0 | v1 | v2 | v3);
    endfunction

endpackage

// File: rtl/demux2x4_8bits_if.sv
// Lane bundle for the demultiplexer: two interleaved input lanes in,
// four rebuilt lanes plus a publication strobe out.
interface demux2x4_8bits_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_00;
    logic             valid_00;
    logic [WIDTH-1:0] data_11;
    logic             valid_11;
    logic [WIDTH-1:0] data_0;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic [WIDTH-1:0] data_3;
    logic             valid_0;
    logic             valid_1;
    logic             valid_2;
    logic             valid_3;
    logic             word_stb;

    modport master (
        output data_00, valid_00, data_11, valid_11,
        input  data_0, data_1, data_2, data_3,
        input  valid_0, valid_1, valid_2, valid_3, word_stb
    );

    modport slave (
        input  data_00, valid_00, data_11, valid_11,
        output data_0, data_1, data_2, data_3,
        output valid_0, valid_1, valid_2, valid_3, word_stb
    );
endinterface

// File: rtl/demux2x4_8bits_phase_ctrl.sv
// Phase FSM of the demultiplexer: locks on first activity, alternates
// even capture / odd publish, and drops back to WAIT on an all-invalid word.
module demux_phase_ctrl
    import demux2x4_8bits_pkg::*;
(
    input  logic clk_2f,
    input  logic reset,
    input  logic valid_00,
    input  logic valid_11,
    input  logic hold_valid_0,
    input  logic hold_valid_2,
    output logic cap_even,
    output logic publish,
    output logic word_stb
);

    phase_e state_r;
    phase_e state_next_s;
    logic   word_stb_r;
    logic   cap_even_s;
    logic   publish_s;
    logic   resync_s;

    assign resync_s = word_all_invalid(hold_valid_0, valid_00, hold_valid_2, valid_11);

    // State register and strobe register.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_r    <= ST_WAIT;
            word_stb_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            word_stb_r <= publish_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = ST_WAIT;
        case (state_r)
            ST_WAIT: begin
                if (valid_00 || valid_11) begin
                    state_next_s = ST_ODD;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_EVEN: state_next_s = ST_ODD;
            ST_ODD: begin
                if (resync_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_EVEN;
                end
            end
            default: state_next_s = ST_WAIT;
        endcase
    end

    // Datapath controls; an active cycle seen in WAIT counts as even phase.
    always_comb begin
        cap_even_s = 1'b0;
        publish_s  = 1'b0;
        case (state_r)
            ST_WAIT: cap_even_s = valid_00 | valid_11;
            ST_EVEN: cap_even_s = 1'b1;
            ST_ODD:  publish_s  = 1'b1;
            default: begin
                cap_even_s = 1'b0;
                publish_s  = 1'b0;
            end
        endcase
    end

    assign cap_even = cap_even_s;
    assign publish  = publish_s;
    assign word_stb = word_stb_r;

endmodule

// File: rtl/demux2x4_8bits.sv
// Rebuilds four parallel lanes from two interleaved fast-rate lanes.
// Even-phase bytes are held one cycle, then published with the odd-phase bytes.
module demux2x4_8bits
    import demux2x4_8bits_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic              clk_2f,
    input  logic              reset,
    demux2x4_8bits_if.slave   bus
);

    logic [WIDTH-1:0] hold0_data_r;
    logic [WIDTH-1:0] hold2_data_r;
    logic             hold0_valid_r;
    logic             hold2_valid_r;
    logic [WIDTH-1:0] data_0_r;
    logic [WIDTH-1:0] data_1_r;
    logic [WIDTH-1:0] data_2_r;
    logic [WIDTH-1:0] data_3_r;
    logic             valid_0_r;
    logic             valid_1_r;
    logic             valid_2_r;
    logic             valid_3_r;
    logic             cap_even_s;
    logic             publish_s;
    logic             word_stb_s;

    demux_phase_ctrl u_phase_ctrl (
        .clk_2f       (clk_2f),
        .reset        (reset),
        .valid_00     (bus.valid_00),
        .valid_11     (bus.valid_11),
        .hold_valid_0 (hold0_valid_r),
        .hold_valid_2 (hold2_valid_r),
        .cap_even     (cap_even_s),
        .publish      (publish_s),
        .word_stb     (word_stb_s)
    );

    // Even-phase holding registers for lanes 0 and 2.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            hold0_data_r  <= {WIDTH{1'b0}};
            hold2_data_r  <= {WIDTH{1'b0}};
            hold0_valid_r <= 1'b0;
            hold2_valid_r <= 1'b0;
        end else if (cap_even_s) begin
            hold0_data_r  <= bus.data_00;
            hold2_data_r  <= bus.data_11;
            hold0_valid_r <= bus.valid_00;
            hold2_valid_r <= bus.valid_11;
        end
    end

    // Output registers; an invalid lane keeps its last data byte.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            data_0_r  <= {WIDTH{1'b0}};
            data_1_r  <= {WIDTH{1'b0}};
            data_2_r  <= {WIDTH{1'b0}};
            data_3_r  <= {WIDTH{1'b0}};
            valid_0_r <= 1'b0;
            valid_1_r <= 1'b0;
            valid_2_r <= 1'b0;
            valid_3_r <= 1'b0;
        end else if (publish_s) begin
            valid_0_r <= hold0_valid_r;
            valid_1_r <= bus.valid_00;
            valid_2_r <= hold2_valid_r;
            valid_3_r <= bus.valid_11;
            if (hold0_valid_r) data_0_r <= hold0_data_r;
            if (bus.valid_00)  data_1_r <= bus.data_00;
            if (hold2_valid_r) data_2_r <= hold2_data_r;
            if (bus.valid_11)  data_3_r <= bus.data_11;
        end
    end

    assign bus.data_0   = data_0_r;
    assign bus.data_1   = data_1_r;
    assign bus.data_2   = data_2_r;
    assign bus.data_3   = data_3_r;
    assign bus.valid_0  = valid_0_r;
    assign bus.valid_1  = valid_1_r;
    assign bus.valid_2  = valid_2_r;
    assign bus.valid_3  = valid_3_r;
    assign bus.word_stb = word_stb_s;

endmodule

// File: tb/tb_demux2x4_8bits.sv
// Self-checking bench for demux2x4_8bits: directed scenarios plus random
// traffic, all checked against a word-level reference model.
module tb_demux2x4_8bits;

    logic clk_2f;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   cyc;

    demux2x4_8bits_if #(.WIDTH(8)) bus ();

    demux2x4_8bits #(.WIDTH(8)) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    // Reference model: expected outputs plus a pending even-phase sample.
    logic [7:0] e_d [4];
    logic       e_v [4];
    logic       e_stb;
    logic       m_active;
    logic       m_pend;
    logic [7:0] p_d0, p_d2;
    logic       p_v0, p_v2;

    wire [36:0] act = {bus.data_0, bus.data_1, bus.data_2, bus.data_3,
                       bus.valid_0, bus.valid_1, bus.valid_2, bus.valid_3, bus.word_stb};

    function automatic logic [36:0] exp_vec();
        return {e_d[0], e_d[1], e_d[2], e_d[3], e_v[0], e_v[1], e_v[2], e_v[3], e_stb};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            e_d[k] = 8'h00;
            e_v[k] = 1'b0;
        end
        e_stb = 1'b0; m_active = 1'b0; m_pend = 1'b0;
        p_d0 = 8'h00; p_d2 = 8'h00; p_v0 = 1'b0; p_v2 = 1'b0;
    endtask

    // Drive one cycle of input, advance the model across the edge, settle.
    task automatic step(input logic [7:0] a, input logic va,
                        input logic [7:0] b, input logic vb);
        logic [7:0] nd [4];
        logic       nv [4];
        bus.data_00 = a; bus.valid_00 = va;
        bus.data_11 = b; bus.valid_11 = vb;
        @(posedge clk_2f);
        if (reset) begin
            model_clear();
        end else begin
            e_stb = 1'b0;
            if (m_pend) begin
                nd[0] = p_d0; nv[0] = p_v0;
                nd[1] = a;    nv[1] = va;
                nd[2] = p_d2; nv[2] = p_v2;
                nd[3] = b;    nv[3] = vb;
                for (int k = 0; k < 4; k++) begin
                    e_v[k] = nv[k];
                    if (nv[k]) e_d[k] = nd[k];
                end
                e_stb    = 1'b1;
                m_pend   = 1'b0;
                m_active = nv[0] | nv[1] | nv[2] | nv[3];
            end else if (m_active || va || vb) begin
                p_d0 = a; p_v0 = va; p_d2 = b; p_v2 = vb;
                m_pend = 1'b1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (act !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h exp %h", act, 37'h0);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(8'h00, 1'b0, 8'h00, 1'b0);
            n_checks++;
            if (act !== 37'h0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got %h exp %h", i, act, 37'h0);
            end
        end
    endtask

    task automatic test_lock_publish();
        step(8'hA0, 1'b1, 8'hC2, 1'b1);
        n_checks++;
        if (bus.word_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_no_stb: got %b exp 0", bus.word_stb);
        end
        step(8'hB1, 1'b1, 8'hD3, 1'b1);
        n_checks++;
        if (act !== {8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'hF, 1'b1}) begin
            n_fail++;
            $display("FAIL lock_word: got %h exp %h", act, {8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'hF, 1'b1});
        end
        n_checks++;
        if (act !== exp_vec()) begin
            n_fail++;
            $display("FAIL lock_model: got %h exp %h", act, exp_vec());
        end
    endtask

    task automatic test_lane_invalid();
        step(8'hE0, 1'b1, 8'hE2, 1'b1);
        step(8'hE1, 1'b1, 8'hFF, 1'b0);
        n_checks++;
        if (act !== {8'hE0, 8'hE1, 8'hE2, 8'hD3, 4'hE, 1'b1}) begin
            n_fail++;
            $display("FAIL lane_invalid: got %h exp %h", act, {8'hE0, 8'hE1, 8'hE2, 8'hD3, 4'hE, 1'b1});
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            step(8'($urandom), 1'b1, 8'($urandom), 1'b1);
            n_checks++;
            if (act !== exp_vec() || bus.word_stb !== 1'(i % 2)) begin
                n_fail++;
                $display("FAIL stream[%0d]: got %h exp %h stb_exp %0d", i, act, exp_vec(), i % 2);
            end
        end
    endtask

    task automatic test_resync();
        int pub_par;
        step(8'h12, 1'b0, 8'h34, 1'b0);
        step(8'h56, 1'b0, 8'h78, 1'b0);
        pub_par = cyc % 2;
        n_checks++;
        if (bus.word_stb !== 1'b1 || {bus.valid_0, bus.valid_1, bus.valid_2, bus.valid_3} !== 4'h0
            || act !== exp_vec()) begin
            n_fail++;
            $display("FAIL resync_publish: got %h exp %h", act, exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b0, 8'h00, 1'b0);
            n_checks++;
            if (bus.word_stb !== 1'b0) begin
                n_fail++;
                $display("FAIL resync_wait[%0d]: got stb %b exp 0", i, bus.word_stb);
            end
        end
        step(8'h11, 1'b1, 8'h22, 1'b1);
        step(8'h33, 1'b1, 8'h44, 1'b1);
        n_checks++;
        if (act !== {8'h11, 8'h33, 8'h22, 8'h44, 4'hF, 1'b1} || (cyc % 2) == pub_par) begin
            n_fail++;
            $display("FAIL relock: got %h exp %h parity %0d old %0d", act,
                     {8'h11, 8'h33, 8'h22, 8'h44, 4'hF, 1'b1}, cyc % 2, pub_par);
        end
    endtask

    task automatic test_reset_mid_word();
        step(8'h55, 1'b1, 8'h55, 1'b1);
        reset = 1'b1;
        step(8'h66, 1'b1, 8'h66, 1'b1);
        reset = 1'b0;
        n_checks++;
        if (act !== 37'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h exp %h", act, 37'h0);
        end
        for (int i = 0; i < 4; i++) begin
            step(8'h00, 1'b0, 8'h00, 1'b0);
            n_checks++;
            if (act !== 37'h0 || bus.data_0 === 8'h55 || bus.data_2 === 8'h55) begin
                n_fail++;
                $display("FAIL mid_reset_after[%0d]: got %h exp %h", i, act, 37'h0);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) < 2)
                step(8'($urandom), 1'b0, 8'($urandom), 1'b0);
            else
                step(8'($urandom), 1'($urandom_range(0, 3) != 0),
                     8'($urandom), 1'($urandom_range(0, 3) != 0));
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h exp %h", i, act, exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus.data_00 = 8'h00; bus.valid_00 = 1'b0;
        bus.data_11 = 8'h00; bus.valid_11 = 1'b0;
        model_clear();
        test_reset();
        test_lock_publish();
        test_lane_invalid();
        test_streaming();
        test_resync();
        test_reset_mid_word();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
